// File: rtl/crypto_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : crypto_frame_builder
// Purpose  : Builds one AES-GCM input frame per command. The frame is the
//            key word, a header word that carries the IV and the last-block
//            size, then the plaintext packed into 128-bit words. Early or
//            missing TLAST on the plaintext stream raises frame_err and is
//            recovered without stalling the crypto stage.
// Ports    : clk, rst_n (async, active-low)
//            cfg_key[127:0], cfg_hdr[95:0], cmd_len[15:0] - sampled at accept
//            cmd_valid / cmd_ready                         - command handshake
//            S_AXIS_* (32-bit)  - plaintext in, first byte at [31:24]
//            M_AXIS_* (128-bit) - frame words out to the crypto stage
//            frame_err          - one-cycle pulse on TLAST mismatch
// Revision : 1.0 - initial release
// ============================================================================
module crypto_frame_builder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] cfg_key,
    input  logic [95:0]  cfg_hdr,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [15:0]  cmd_len,
    input  logic         S_AXIS_TVALID,
    output logic         S_AXIS_TREADY,
    input  logic [31:0]  S_AXIS_TDATA,
    input  logic         S_AXIS_TLAST,
    output logic         M_AXIS_TVALID,
    input  logic         M_AXIS_TREADY,
    output logic [127:0] M_AXIS_TDATA,
    output logic         M_AXIS_TLAST,
    output logic         frame_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY   = 3'd1,
        HDR   = 3'd2,
        PACK  = 3'd3,
        SEND  = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [127:0]   r_key;
    logic [95:0]    r_hdr;
    logic [15:0]    r_len;
    logic [13:0]    r_beat_cnt;
    logic [11:0]    r_word_cnt;
    logic [127:0]   r_buf;
    logic           r_early;      // early TLAST seen: pad the rest with zeros
    logic           r_owe;        // TLAST still owed: drain after the frame
    logic           r_frame_err;
    logic           r_cmd_ready;

    logic [15:0]    w_len_m1;
    logic [13:0]    w_last_beat_idx;
    logic [11:0]    w_last_word_idx;
    logic [1:0]     w_tail_bytes_m1;
    logic           w_cmd_fire;
    logic           w_beat_fire;
    logic           w_is_last_beat;
    logic           w_is_last_word;
    logic           w_early_tlast;
    logic           w_missing_tlast;
    logic           w_word_done;
    logic           w_send_fire;
    logic [31:0]    w_beat_masked;
    logic [127:0]   w_beat_placed;

    // len-1 gives the last beat index (>>2), last word index (>>4) and the
    // number of valid bytes in the final beat (low two bits + 1) directly,
    // so no counter ever has to reach a "total" value that would overflow.
    assign w_len_m1        = r_len - 16'd1;
    assign w_last_beat_idx = w_len_m1[15:2];
    assign w_last_word_idx = w_len_m1[15:4];
    assign w_tail_bytes_m1 = w_len_m1[1:0];

    assign w_cmd_fire      = (r_state == IDLE) && cmd_valid && r_cmd_ready;
    assign w_beat_fire     = (r_state == PACK) && !r_early && S_AXIS_TVALID;
    assign w_is_last_beat  = (r_beat_cnt == w_last_beat_idx);
    assign w_is_last_word  = (r_word_cnt == w_last_word_idx);
    assign w_early_tlast   = w_beat_fire && S_AXIS_TLAST && !w_is_last_beat;
    assign w_missing_tlast = w_beat_fire && !S_AXIS_TLAST && w_is_last_beat;
    assign w_word_done     = (r_beat_cnt[1:0] == 2'd3) || w_is_last_beat || S_AXIS_TLAST;
    assign w_send_fire     = (r_state == SEND) && M_AXIS_TREADY;

    // Zero the bytes past the end of the frame in the final beat.
    always_comb begin
        w_beat_masked = S_AXIS_TDATA;
        if (w_is_last_beat) begin
            case (w_tail_bytes_m1)
                2'd0:    w_beat_masked = S_AXIS_TDATA & 32'hFF00_0000;
                2'd1:    w_beat_masked = S_AXIS_TDATA & 32'hFFFF_0000;
                2'd2:    w_beat_masked = S_AXIS_TDATA & 32'hFFFF_FF00;
                default: w_beat_masked = S_AXIS_TDATA;
            endcase
        end
    end

    // Beat k of a word lands at [127-32k : 96-32k].
    assign w_beat_placed = {w_beat_masked, 96'd0} >> {r_beat_cnt[1:0], 5'd0};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) w_next_state = KEY;
            end
            KEY: begin
                if (M_AXIS_TREADY) w_next_state = HDR;
            end
            HDR: begin
                if (M_AXIS_TREADY) w_next_state = PACK;
            end
            PACK: begin
                // After an early TLAST every remaining word is all zeros,
                // so it goes straight out without touching the input.
                if (r_early) begin
                    w_next_state = SEND;
                end else if (w_beat_fire && w_word_done) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (M_AXIS_TREADY) begin
                    if (!w_is_last_word) begin
                        w_next_state = PACK;
                    end else if (r_owe) begin
                        w_next_state = DRAIN;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (S_AXIS_TVALID && S_AXIS_TLAST) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key       <= 128'd0;
            r_hdr       <= 96'd0;
            r_len       <= 16'd1;
            r_beat_cnt  <= 14'd0;
            r_word_cnt  <= 12'd0;
            r_buf       <= 128'd0;
            r_early     <= 1'b0;
            r_owe       <= 1'b0;
            r_frame_err <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            // Registered so that cmd_ready is low throughout reset and
            // rises on the first edge after release.
            r_cmd_ready <= (w_next_state == IDLE);
            r_frame_err <= w_early_tlast | w_missing_tlast;
            if (w_cmd_fire) begin
                r_key      <= cfg_key;
                r_hdr      <= cfg_hdr;
                r_len      <= (cmd_len == 16'd0) ? 16'd1 : cmd_len;
                r_beat_cnt <= 14'd0;
                r_word_cnt <= 12'd0;
                r_buf      <= 128'd0;
                r_early    <= 1'b0;
                r_owe      <= 1'b0;
            end else begin
                if (w_beat_fire) begin
                    r_beat_cnt <= r_beat_cnt + 14'd1;
                    r_buf      <= r_buf | w_beat_placed;
                    if (w_early_tlast)   r_early <= 1'b1;
                    if (w_missing_tlast) r_owe   <= 1'b1;
                end
                if (w_send_fire) begin
                    r_buf <= 128'd0;
                    if (!w_is_last_word) r_word_cnt <= r_word_cnt + 12'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and held registers, so they stay stable
    // for as long as a word is stalled.
    // ------------------------------------------------------------------
    always_comb begin
        M_AXIS_TDATA = 128'd0;
        case (r_state)
            KEY:     M_AXIS_TDATA = r_key;
            HDR:     M_AXIS_TDATA = {r_hdr[95:68], r_len[3:0], r_hdr[63:0], 32'h0};
            SEND:    M_AXIS_TDATA = r_buf;
            default: M_AXIS_TDATA = 128'd0;
        endcase
    end

    assign M_AXIS_TVALID = (r_state == KEY) || (r_state == HDR) || (r_state == SEND);
    assign M_AXIS_TLAST  = (r_state == SEND) && w_is_last_word;
    assign S_AXIS_TREADY = ((r_state == PACK) && !r_early) || (r_state == DRAIN);
    assign cmd_ready     = r_cmd_ready;
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: doc/crypto_frame_builder.md
CRYPTO_FRAME_BUILDER -- requirements
Module: crypto_frame_builder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: cfg_key  in  128  AES-128 key, sampled at command accept.
REQ-004 SHALL have ports: cfg_hdr  in  96  IV/header field, sampled at command accept.
REQ-005 SHALL have ports: cmd_valid / cmd_ready  in / out  1 / 1  frame-command handshake.
REQ-006 SHALL have ports: cmd_len  in  16  plaintext length in bytes, 1..65535; 0 is illegal.
REQ-007 SHALL have ports: S_AXIS_TVALID / S_AXIS_TREADY / S_AXIS_TDATA / S_AXIS_TLAST  in / out / in / in  1 / 1 / 32 / 1  plaintext byte stream, first byte at [31:24].
REQ-008 SHALL have ports: M_AXIS_TVALID / M_AXIS_TREADY / M_AXIS_TDATA / M_AXIS_TLAST  out / in / out / out  1 / 1 / 128 / 1  stream to the AES-GCM crypto stage.
REQ-009 SHALL have ports: frame_err  out  1  one-cycle pulse on TLAST mismatch.

Function
REQ-010 SHALL use states IDLE, KEY, HDR, PACK, SEND, DRAIN.
REQ-011 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL latch key, hdr and len, and go to KEY; cmd_ready=0 in every other state.
REQ-012 KEY: M_AXIS_TDATA=key, TVALID=1 starting the cycle after command accept; on TREADY SHALL go to HDR.
REQ-013 HDR: M_AXIS_TDATA = {hdr[95:68], lbs[3:0], hdr[63:0], 32'h0}, where lbs = len mod 16 (0 encodes 16); on TREADY SHALL go to PACK.
REQ-014 PACK: S_AXIS_TREADY=1; each accepted beat SHALL be placed in the 128-bit word buffer, beat k (0..3) at bits [127-32k:96-32k].
REQ-015 Bytes beyond len in the final beat and unfilled beat slots in the final word SHALL be zero.
REQ-016 PACK SHALL go to SEND after the 4th beat or the frame's final expected beat (ceil(len/4) beats total), whichever comes first.
REQ-017 SEND: S_AXIS_TREADY=0; M_AXIS_TVALID=1 the cycle after the last buffered beat; TLAST=1 only on word ceil(len/16).
REQ-018 SEND: on TREADY SHALL return to PACK, or go to IDLE after the last word (DRAIN if TLAST is owed, see REQ-021).
REQ-019 M_AXIS_TDATA/TLAST SHALL stay stable while TVALID=1 and TREADY=0; TVALID SHALL never drop before acceptance.
REQ-020 Early TLAST (TLAST on a beat before the final expected beat): frame_err pulse; remaining bytes of the frame zero-filled; remaining words emitted normally with no further input accepted.
REQ-021 Missing TLAST on the final expected beat: frame_err pulse; frame finishes normally; then DRAIN with S_AXIS_TREADY=1, discarding beats through the one with TLAST, then IDLE.
REQ-022 Beat counter 14 bits; word counter 12 bits; neither SHALL wrap within a legal frame (max 16384 beats, 4096 words).
REQ-023 cmd_len=0 SHALL be treated as 1 (one word, lbs=1).
REQ-024 M_AXIS words per frame SHALL be exactly 2 + ceil(len/16).

Reset
REQ-025 rst_n low SHALL force, asynchronously: state=IDLE, cmd_ready=0, S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, frame_err=0, counters=0.
REQ-026 The first clock edge after rst_n rises SHALL set cmd_ready=1.
REQ-027 Reset mid-frame SHALL abort the frame with no further output; the partial frame is not resumed.

Verification
REQ-028 len=32, 8 beats 0x00010203.., TREADY=1 -> 4 words: key, hdr with [99:96]=0, data word0, data word1 with TLAST=1.
REQ-029 len=5, beats 0xAABBCCDD,0xEEFF0011 (TLAST) -> 3 words; data = 0xAABBCCDD_EE000000_00000000_00000000 with TLAST; hdr [99:96]=5.
REQ-030 len=20, M_AXIS_TREADY toggled 1-0-0-1 each cycle -> TDATA stable while stalled; 4 words total; no beat loss.
REQ-031 len=16, TLAST on beat 2 -> frame_err pulse once; data word = beats0..1 then 64 zero bits, TLAST=1; then IDLE.
REQ-032 len=8, TLAST only on beat 4 -> frame_err pulse; 3 words out; beats 3..4 discarded in DRAIN; next command accepted.
REQ-033 rst_n pulled low during SEND of word 2 of len=48 -> TVALID=0 immediately; cmd_ready=1 one edge after release; new frame correct.
